// File: rtl/droop_tap_cal.sv
// Anti-droop tap calibration: compares late (B) vs early (A) pulse windows and steps tapWeight one LSB per pass.
// Define DROOP_CAL_AVG_EN for 4-sample windows; otherwise each window is a single sample scaled by 4.
module droop_tap_cal #(
   parameter int SETTLE_DLY = 16,
   parameter int WIN_LEN    = 256,
   parameter int DEADBAND   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               trig,
   input  logic               cal_en,
   input  logic signed [15:0] din,
   input  logic signed [6:0]  tapWeight_init,
   input  logic               load_init,
   output logic signed [6:0]  tapWeight,
   output logic               cal_busy,
   output logic               cal_done,
   output logic               sat_flag
);

`ifdef DROOP_CAL_AVG_EN
   localparam int SAMP_LEN = 4;
`else
   localparam int SAMP_LEN = 1;
`endif
   localparam int MAX_DLY = (SETTLE_DLY > WIN_LEN) ? SETTLE_DLY : WIN_LEN;
   localparam int CW = $clog2(MAX_DLY + 1) + 1;
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_DLY - 1);
   localparam logic [CW-1:0] WAIT_LAST   = CW'(WIN_LEN - 1);
   localparam logic [CW-1:0] SAMP_LAST   = CW'(SAMP_LEN - 1);
   localparam logic signed [18:0] DB     = 19'(DEADBAND);
   localparam logic signed [6:0]  TW_MAX = 7'b0111111;
   localparam logic signed [6:0]  TW_MIN = 7'b1000000;

   typedef enum logic [2:0] {IDLE, SETTLE, SAMPA, WAIT, SAMPB, UPDATE} state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic               trig_a;
   logic               trig_b;
   logic               trig_edge;
   logic signed [17:0] acc_a;
   logic signed [17:0] acc_b;
   logic signed [17:0] samp_a;
   logic signed [17:0] samp_b;
   logic signed [18:0] diff;
   logic               inc_req;
   logic               dec_req;

   assign trig_edge = trig_a & ~trig_b;

`ifdef DROOP_CAL_AVG_EN
   logic signed [17:0] din_ext;
   assign din_ext = {{2{din[15]}}, din};
   assign samp_a  = acc_a + din_ext;
   assign samp_b  = acc_b + din_ext;
`else
   // Single sample scaled by 4 keeps DEADBAND in the same units as the 4-sample sum.
   assign samp_a = {din, 2'b00};
   assign samp_b = {din, 2'b00};
`endif

   assign diff    = {acc_b[17], acc_b} - {acc_a[17], acc_a};
   assign inc_req = diff < -DB;
   assign dec_req = diff > DB;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         trig_a    <= 1'b0;
         trig_b    <= 1'b0;
         acc_a     <= '0;
         acc_b     <= '0;
         tapWeight <= '0;
         cal_busy  <= 1'b0;
         cal_done  <= 1'b0;
         sat_flag  <= 1'b0;
      end else begin
         trig_a   <= trig;
         trig_b   <= trig_a;
         cal_done <= 1'b0;
         if (load_init) begin
            tapWeight <= tapWeight_init;
            sat_flag  <= 1'b0;
            state     <= IDLE;
            cal_busy  <= 1'b0;
            cnt       <= '0;
         end else if (!cal_en) begin
            state    <= IDLE;
            cal_busy <= 1'b0;
            cnt      <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (trig_edge) begin
                     state    <= SETTLE;
                     cal_busy <= 1'b1;
                     cnt      <= '0;
                  end
               end
               SETTLE: begin
                  if (cnt == SETTLE_LAST) begin
                     state <= SAMPA;
                     cnt   <= '0;
                     acc_a <= '0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               SAMPA: begin
                  acc_a <= samp_a;
                  if (cnt == SAMP_LAST) begin
                     state <= WAIT;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               WAIT: begin
                  if (cnt == WAIT_LAST) begin
                     state <= SAMPB;
                     cnt   <= '0;
                     acc_b <= '0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               SAMPB: begin
                  acc_b <= samp_b;
                  if (cnt == SAMP_LAST) begin
                     state <= UPDATE;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               UPDATE: begin
                  // Negative diff means the tail sagged: more compensation needed.
                  state    <= IDLE;
                  cal_busy <= 1'b0;
                  cal_done <= 1'b1;
                  if (inc_req) begin
                     if (tapWeight == TW_MAX) sat_flag <= 1'b1;
                     else tapWeight <= tapWeight + 7'sd1;
                  end else if (dec_req) begin
                     if (tapWeight == TW_MIN) sat_flag <= 1'b1;
                     else tapWeight <= tapWeight - 7'sd1;
                  end
               end
               default: begin
                  state    <= IDLE;
                  cal_busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_droop_tap_cal.sv
// Directed bench for droop_tap_cal: scoreboard of expected tapWeight/sat_flag/cycle per pass, checked on cal_done.
module tb_droop_tap_cal;
   localparam int S  = 16;
   localparam int W  = 256;
   localparam int DB = 8;
`ifdef DROOP_CAL_AVG_EN
   localparam int SAMP = 4;
`else
   localparam int SAMP = 1;
`endif
   localparam int LAT = S + SAMP + W + SAMP + 1;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               trig;
   logic               cal_en;
   logic signed [15:0] din;
   logic signed [6:0]  tapWeight_init;
   logic               load_init;
   logic signed [6:0]  tapWeight;
   logic               cal_busy;
   logic               cal_done;
   logic               sat_flag;

   typedef struct {
      logic signed [6:0] tw;
      logic              sat;
      int                cyc;
   } exp_t;

   exp_t              sb[$];
   exp_t              mon_e;
   int                cyc = 0;
   int                n_assert = 0;
   int                n_fail = 0;
   logic signed [6:0] exp_tw;
   logic              exp_sat;

   droop_tap_cal #(.SETTLE_DLY(S), .WIN_LEN(W), .DEADBAND(DB)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .trig(trig),
      .cal_en(cal_en),
      .din(din),
      .tapWeight_init(tapWeight_init),
      .load_init(load_init),
      .tapWeight(tapWeight),
      .cal_busy(cal_busy),
      .cal_done(cal_done),
      .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] req);
      n_assert++;
      assert (obs === req) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_until(input int t);
      while (cyc < t) tick();
   endtask

   task automatic idle_wait(input int n, output int dones);
      dones = 0;
      repeat (n) begin
         tick();
         if (cal_done === 1'b1) dones++;
      end
   endtask

   // Expected step for flat windows: diff = 4 * (B - A) in either window mode.
   task automatic model(input int va, input int vb);
      int diff;
      int cur;
      diff = (vb - va) * 4;
      cur  = exp_tw;
      if (diff < -DB) begin
         if (cur == 63) exp_sat = 1'b1;
         else exp_tw = exp_tw + 7'sd1;
      end else if (diff > DB) begin
         if (cur == -64) exp_sat = 1'b1;
         else exp_tw = exp_tw - 7'sd1;
      end
   endtask

   task automatic load(input logic signed [6:0] v);
      tapWeight_init = v;
      load_init = 1'b1;
      tick();
      load_init = 1'b0;
      exp_tw  = v;
      exp_sat = 1'b0;
      chk("load_tw", tapWeight, v);
   endtask

   task automatic run_pass(input logic signed [15:0] va, input logic signed [15:0] vb, input bit retrig);
      int   c0;
      bit   seen;
      exp_t e;
      din = va;
      tick();
      model(va, vb);
      c0    = cyc;
      e.tw  = exp_tw;
      e.sat = exp_sat;
      e.cyc = c0 + 2 + LAT;
      sb.push_back(e);
      trig = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < LAT + 20 && !seen; i++) begin
         tick();
         if (cyc == c0 + 3) chk("busy_in_pass", cal_busy, 1);
         if (cyc == c0 + 4) trig = 1'b0;
         if (cyc == c0 + 2 + S + SAMP + W / 2) din = vb;
         if (retrig && cyc == c0 + LAT) trig = 1'b1;
         if (cal_done === 1'b1) seen = 1'b1;
      end
      chk("done_seen", seen, 1);
      if (!seen && sb.size() != 0) void'(sb.pop_front());
      tick();
      chk("done_one_cycle", cal_done, 0);
      chk("busy_after_done", cal_busy, 0);
      din = va;
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && cal_done === 1'b1) begin
         chk("done_expected", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("sb_tapWeight", tapWeight, mon_e.tw);
            chk("sb_sat_flag", sat_flag, mon_e.sat);
            chk("sb_done_cycle", cyc, mon_e.cyc);
         end
      end
   end

   initial begin
      int c0;
      int nd;
      rst_n = 1'b0; trig = 1'b0; cal_en = 1'b0; din = '0;
      tapWeight_init = '0; load_init = 1'b0;
      exp_tw = '0; exp_sat = 1'b0;
      repeat (3) tick();
      chk("rst_tapWeight", tapWeight, 0);
      chk("rst_busy", cal_busy, 0);
      chk("rst_done", cal_done, 0);
      chk("rst_sat", sat_flag, 0);
      rst_n = 1'b1; cal_en = 1'b1;
      tick();

      run_pass(16'sd1000, 16'sd1000, 1'b0);
      load(7'sd5);
      run_pass(16'sd1000, 16'sd990, 1'b0);
      run_pass(16'sd1000, 16'sd1003, 1'b0);
      run_pass(16'sd1000, 16'sd1002, 1'b0);
      run_pass(16'sd1002, 16'sd1000, 1'b0);
      load(7'sd63);
      run_pass(16'sd1000, 16'sd990, 1'b0);
      run_pass(16'sd1000, 16'sd1000, 1'b0);

      // Drop cal_en while waiting between windows.
      din = 16'sd1000; tick(); c0 = cyc; trig = 1'b1;
      repeat (4) tick();
      trig = 1'b0;
      run_until(c0 + 2 + S + SAMP + 10);
      chk("abort_busy_before", cal_busy, 1);
      cal_en = 1'b0; din = 16'sd990;
      tick();
      chk("abort_busy", cal_busy, 0);
      cal_en = 1'b1;
      idle_wait(LAT + 10, nd);
      chk("abort_no_done", nd, 0);
      chk("abort_tapWeight", tapWeight, exp_tw);
      chk("abort_sat", sat_flag, exp_sat);

      // load_init while in the B window.
      din = 16'sd1000; tick(); c0 = cyc; trig = 1'b1;
      repeat (4) tick();
      trig = 1'b0;
      run_until(c0 + 2 + S + SAMP + W / 2);
      din = 16'sd990;
      run_until(c0 + 2 + S + SAMP + W);
      chk("sampb_busy", cal_busy, 1);
      tapWeight_init = -7'sd20; load_init = 1'b1;
      tick();
      load_init = 1'b0; exp_tw = -7'sd20; exp_sat = 1'b0;
      chk("ld_tapWeight", tapWeight, -20);
      chk("ld_sat", sat_flag, 0);
      chk("ld_busy", cal_busy, 0);
      idle_wait(LAT, nd);
      chk("ld_no_done", nd, 0);
      chk("ld_tapWeight_hold", tapWeight, -20);

      // Reset in the middle of a pass.
      din = 16'sd1000; tick(); c0 = cyc; trig = 1'b1;
      repeat (4) tick();
      trig = 1'b0;
      run_until(c0 + 2 + S + SAMP + W / 2);
      din = 16'sd990;
      rst_n = 1'b0;
      tick();
      exp_tw = '0; exp_sat = 1'b0;
      chk("mid_rst_tapWeight", tapWeight, 0);
      chk("mid_rst_busy", cal_busy, 0);
      chk("mid_rst_done", cal_done, 0);
      chk("mid_rst_sat", sat_flag, 0);
      rst_n = 1'b1;
      idle_wait(LAT, nd);
      chk("mid_rst_no_done", nd, 0);
      run_pass(16'sd1000, 16'sd990, 1'b0);

      // Edge landing on the UPDATE cycle must not start another pass.
      run_pass(16'sd1000, 16'sd1000, 1'b1);
      idle_wait(LAT + 10, nd);
      chk("update_edge_no_done", nd, 0);
      chk("update_edge_idle", cal_busy, 0);
      trig = 1'b0;
      tick();
      chk("scoreboard_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/droop_tap_cal.md
DROOP_TAP_CAL -- requirements
Module: droop_tap_cal

Interface
REQ-001 SHALL have parameter SETTLE_DLY, default 16: cycles from trigger edge to the first window sample.
REQ-002 SHALL have parameter WIN_LEN, default 256: cycles between the end of sample window A and the start of sample window B.
REQ-003 SHALL have parameter DEADBAND, default 8: unsigned no-adjust threshold, in accumulator units.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port trig, input, 1 bit: pulse trigger, asynchronous to the pulse timing.
REQ-007 SHALL have port cal_en, input, 1 bit: enables calibration.
REQ-008 SHALL have port din, input, signed 16 bits: corrected (anti-droop filter output) samples.
REQ-009 SHALL have port tapWeight_init, input, signed 7 bits: preload value for the tap weight.
REQ-010 SHALL have port load_init, input, 1 bit: loads tapWeight_init into tapWeight.
REQ-011 SHALL have port tapWeight, output reg, signed 7 bits: calibrated weight fed to the anti-droop filter.
REQ-012 SHALL have port cal_busy, output reg, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port cal_done, output reg, 1 bit: one-cycle pulse when a calibration pass completes.
REQ-014 SHALL have port sat_flag, output reg, 1 bit: sticky flag, set when an adjustment is blocked at a tapWeight limit.

Function
REQ-015 SHALL register trig through two flops and form trig_edge = trig_a & ~trig_b.
REQ-016 SHALL implement FSM states IDLE, SETTLE, SAMPA, WAIT, SAMPB, UPDATE.
REQ-017 SHALL go IDLE->SETTLE on trig_edge & cal_en; trig_edge is ignored in all other states.
REQ-018 SHALL dwell exactly SETTLE_DLY cycles in SETTLE and exactly WIN_LEN cycles in WAIT, then advance.
REQ-019 SHALL, in SAMPA/SAMPB, accumulate din into signed 18-bit accA/accB; each accumulator is cleared on entry to its state.
REQ-020 SHALL, in UPDATE (1 cycle), compute diff = accB - accA as signed 19 bits with no overflow.
REQ-021 SHALL apply the UPDATE adjustment: diff < -DEADBAND -> tapWeight+1; diff > +DEADBAND -> tapWeight-1; otherwise unchanged.
REQ-022 SHALL saturate tapWeight at +63 and -64; a blocked step leaves tapWeight unchanged and sets sat_flag.
REQ-023 SHALL update tapWeight and pulse cal_done on the clock edge leaving UPDATE, then return to IDLE.
REQ-024 SHALL apply priority load_init > ~cal_en > FSM.
REQ-025 SHALL, on load_init in any state, set tapWeight=tapWeight_init, clear sat_flag, go to IDLE, with no cal_done.
REQ-026 SHALL, on cal_en low in a non-IDLE state, abort to IDLE with tapWeight unchanged and no cal_done.
REQ-027 SHALL, when trig_edge coincides with the UPDATE cycle, ignore the edge; a new pass needs a later edge.

Reset
REQ-028 SHALL, on rst_n=0 at a clock edge: state=IDLE, tapWeight=0, cal_busy=0, cal_done=0, sat_flag=0, trig flops=0, accumulators=0, counters=0.
REQ-029 SHALL give reset priority over load_init; reset mid-pass discards the pass.

Configuration
REQ-030 SHALL support macro DROOP_CAL_AVG_EN.
REQ-031 SHALL, when DROOP_CAL_AVG_EN is defined: SAMPA/SAMPB each last 4 cycles, and acc = sum of 4 din.
REQ-032 SHALL, when DROOP_CAL_AVG_EN is undefined: SAMPA/SAMPB each last 1 cycle, acc = din<<<2, so DEADBAND units match.

Verification
REQ-033 SHALL cover: din flat 1000, AVG on, trig -> cal_done after SETTLE_DLY+4+WIN_LEN+4+1 FSM cycles; tapWeight stays 0.
REQ-034 SHALL cover: A window 1000, B window 990 (diff=-40), tapWeight=5 -> tapWeight=6, cal_done one cycle.
REQ-035 SHALL cover: tapWeight=63, droop diff=-40 -> tapWeight stays 63, sat_flag=1 until load_init.
REQ-036 SHALL cover: B-A=+2 per sample (diff=+8), AVG on -> no change (deadband inclusive).
REQ-037 SHALL cover: cal_en dropped in WAIT -> IDLE, cal_busy=0, no cal_done, tapWeight unchanged.
REQ-038 SHALL cover: load_init with tapWeight_init=-20 during SAMPB -> tapWeight=-20, IDLE, sat_flag=0; rst_n low mid-pass -> all outputs 0.
